// File: rtl/spi_cmd_sequencer.sv
// Frame-level command sequencer sitting behind a byte-oriented SPI slave.
// Each CS frame carries one command byte followed by an auto-incrementing
// burst of register writes or reads; rejected frames answer with ERR_BYTE.
module spi_cmd_sequencer #(
   parameter int          NUM_REGS  = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter logic [7:0]  ERR_BYTE  = 8'hEE,
   localparam int         ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_active,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic [7:0]        tx_byte,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              reg_wr_en,
   output logic [7:0]        reg_wdata,
   input  logic [7:0]        reg_rdata,
   output logic              frame_err,
   output logic [7:0]        cmd_count,
   output logic [7:0]        err_count
);

   typedef enum logic [2:0] {IDLE, CMD, RD_FETCH, RD_WAIT, WR, ERR} state_t;

   state_t state, state_nxt;

   logic [7:0]        tx_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              wr_en_nxt;
   logic [7:0]        wdata_nxt;
   logic              ferr_nxt;
   logic [7:0]        cmd_cnt_nxt;
   logic [7:0]        err_cnt_nxt;
   logic              cmd_ok;
   logic              byte_in;

   // Burst address advance, wrapping at the top of the register bank
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(NUM_REGS - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

   // A byte only counts while the frame is still open
   assign byte_in = rx_valid && frame_active;
   assign cmd_ok  = (rx_byte[6:4] == 3'b000) && (int'(rx_byte[3:0]) < NUM_REGS);

   // State register plus registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx_byte   <= 8'h00;
         reg_addr  <= '0;
         reg_wr_en <= 1'b0;
         reg_wdata <= 8'h00;
         frame_err <= 1'b0;
         cmd_count <= 8'h00;
         err_count <= 8'h00;
      end else begin
         state     <= state_nxt;
         tx_byte   <= tx_nxt;
         reg_addr  <= addr_nxt;
         reg_wr_en <= wr_en_nxt;
         reg_wdata <= wdata_nxt;
         frame_err <= ferr_nxt;
         cmd_count <= cmd_cnt_nxt;
         err_count <= err_cnt_nxt;
      end
   end

   // Next-state decode; a closed frame always returns to IDLE
   always_comb begin
      state_nxt = state;
      if (!frame_active) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:     state_nxt = CMD;
            CMD:      if (rx_valid) state_nxt = !cmd_ok ? ERR : (rx_byte[7] ? RD_FETCH : WR);
            RD_FETCH: state_nxt = RD_WAIT;
            RD_WAIT:  if (rx_valid) state_nxt = RD_FETCH;
            WR:       state_nxt = WR;
            ERR:      state_nxt = ERR;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   // Next values of the registered outputs for the current state
   always_comb begin
      tx_nxt      = tx_byte;
      addr_nxt    = reg_addr;
      wr_en_nxt   = 1'b0;
      wdata_nxt   = reg_wdata;
      ferr_nxt    = frame_err;
      cmd_cnt_nxt = cmd_count;
      err_cnt_nxt = err_count;
      if (reg_wr_en) begin
         addr_nxt = next_addr(reg_addr);
      end
      unique case (state)
         IDLE: begin
            if (frame_active) tx_nxt = SYNC_BYTE;
         end
         CMD: begin
            if (byte_in) begin
               if (!cmd_ok) begin
                  tx_nxt      = ERR_BYTE;
                  ferr_nxt    = 1'b1;
                  err_cnt_nxt = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
               end else begin
                  cmd_cnt_nxt = cmd_count + 8'd1;
                  ferr_nxt    = 1'b0;
                  addr_nxt    = rx_byte[ADDR_W-1:0];
               end
            end
         end
         RD_FETCH: begin
            if (frame_active) tx_nxt = reg_rdata;
         end
         RD_WAIT: begin
            if (byte_in) addr_nxt = next_addr(reg_addr);
         end
         WR: begin
            if (byte_in) begin
               wr_en_nxt = 1'b1;
               wdata_nxt = rx_byte;
            end
         end
         ERR: begin
            tx_nxt = tx_byte;
         end
         default: begin
            tx_nxt = tx_byte;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer: directed frames plus random
// frames, compared against a frame-level model of the register bank.
module tb_spi_cmd_sequencer;

   localparam int NUM_REGS = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_active;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic [7:0] tx_byte;
   logic [3:0] reg_addr;
   logic       reg_wr_en;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       frame_err;
   logic [7:0] cmd_count;
   logic [7:0] err_count;

   spi_cmd_sequencer #(.NUM_REGS(NUM_REGS)) dut (
      .clk(clk), .rst_n(rst_n), .frame_active(frame_active), .rx_valid(rx_valid),
      .rx_byte(rx_byte), .tx_byte(tx_byte), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .frame_err(frame_err),
      .cmd_count(cmd_count), .err_count(err_count)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   logic [7:0]  bank [NUM_REGS];
   logic [7:0]  model_mem [NUM_REGS];
   logic [11:0] wr_log [$];
   logic [7:0]  frame_q [$];
   logic        preload_en = 1'b0;
   logic [3:0]  preload_addr = 4'd0;
   logic [7:0]  preload_data = 8'd0;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cmd_model = 0;
   int   err_model = 0;
   logic ferr_model = 1'b0;
   logic [3:0] addr_model = 4'd0;

   // Register bank behind the DUT; every write strobe is also logged
   assign reg_rdata = bank[reg_addr];
   always @(posedge clk) begin
      if (preload_en) bank[preload_addr] <= preload_data;
      if (reg_wr_en) begin
         bank[reg_addr] <= reg_wdata;
         wr_log.push_back({reg_addr, reg_wdata});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] a, input logic [7:0] d);
      preload_addr = a;
      preload_data = d;
      preload_en   = 1'b1;
      tick;
      preload_en   = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick;
      rx_valid = 1'b0;
      repeat (4) tick;
   endtask

   function automatic logic [3:0] wrap_inc(input logic [3:0] a);
      return (int'(a) == NUM_REGS - 1) ? 4'd0 : a + 4'd1;
   endfunction

   // Registered status outputs against the model
   task automatic checkOutput(input string tag);
      check8({tag, "_ferr"}, {7'd0, frame_err}, {7'd0, ferr_model});
      check8({tag, "_cmdcnt"}, cmd_count, 8'(cmd_model % 256));
      check8({tag, "_errcnt"}, err_count, 8'(err_model));
      check8({tag, "_addr"}, {4'd0, reg_addr}, {4'd0, addr_model});
   endtask

   // Plays frame_q as one CS frame and checks MISO bytes, writes and status
   task automatic run_frame(input string tag);
      logic [7:0]  cmd;
      logic        ok, rd;
      logic [7:0]  exp_tx;
      logic [11:0] exp_w [$];
      cmd = frame_q[0];
      ok  = (cmd[6:4] == 3'd0) && (int'(cmd[3:0]) < NUM_REGS);
      rd  = cmd[7];
      wr_log.delete();
      frame_active = 1'b1;
      tick;
      tick;
      check8({tag, "_sync"}, tx_byte, 8'hA5);
      applyStimulus(cmd);
      if (ok) begin
         cmd_model++;
         ferr_model = 1'b0;
         addr_model = cmd[3:0];
      end else begin
         if (err_model < 255) err_model++;
         ferr_model = 1'b1;
      end
      exp_tx = !ok ? 8'hEE : (rd ? model_mem[addr_model] : 8'hA5);
      check8({tag, "_tx0"}, tx_byte, exp_tx);
      for (int i = 1; i < frame_q.size(); i++) begin
         if (ok && !rd) begin
            exp_w.push_back({addr_model, frame_q[i]});
            model_mem[addr_model] = frame_q[i];
            addr_model = wrap_inc(addr_model);
         end else if (ok) begin
            addr_model = wrap_inc(addr_model);
         end
         applyStimulus(frame_q[i]);
         exp_tx = !ok ? 8'hEE : (rd ? model_mem[addr_model] : 8'hA5);
         check8($sformatf("%s_tx%0d", tag, i), tx_byte, exp_tx);
      end
      frame_active = 1'b0;
      tick;
      checkOutput(tag);
      check_int({tag, "_nwr"}, wr_log.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++)
         check_int($sformatf("%s_wr%0d", tag, i), int'(wr_log[i]), int'(exp_w[i]));
   endtask

   // Directed scenarios followed by random frames and counter saturation
   initial begin
      logic [31:0] r;
      logic [7:0]  cmd_before;
      rst_n = 1'b0;
      frame_active = 1'b0;
      rx_valid = 1'b0;
      rx_byte = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) preload(4'(i), 8'($urandom));
      check8("rst_tx", tx_byte, 8'h00);
      check8("rst_wren", {7'd0, reg_wr_en}, 8'h00);
      check8("rst_wdata", reg_wdata, 8'h00);
      checkOutput("rst");
      rst_n = 1'b1;
      tick;

      frame_q = '{8'h02, 8'h11, 8'h22, 8'h33};
      run_frame("write");

      preload(4'd15, 8'h5A);
      preload(4'd0, 8'hC3);
      frame_q = '{8'h8F, 8'h00, 8'hFF};
      run_frame("rdwrap");

      frame_q = '{8'h92, 8'h44};
      run_frame("reject");
      frame_q = '{8'h85, 8'h01};
      run_frame("clear");

      wr_log.delete();
      frame_active = 1'b1;
      tick;
      tick;
      applyStimulus(8'h02);
      applyStimulus(8'h11);
      rx_byte = 8'h22;
      rx_valid = 1'b1;
      frame_active = 1'b0;
      tick;
      rx_valid = 1'b0;
      repeat (3) tick;
      cmd_model++;
      ferr_model = 1'b0;
      model_mem[2] = 8'h11;
      addr_model = 4'd3;
      checkOutput("csdrop");
      check_int("csdrop_nwr", wr_log.size(), 1);
      if (wr_log.size() > 0) check_int("csdrop_wr0", int'(wr_log[0]), int'(12'h211));
      frame_q = '{8'h81};
      run_frame("after_drop");

      wr_log.delete();
      frame_active = 1'b1;
      tick;
      tick;
      applyStimulus(8'h05);
      rx_byte = 8'h77;
      rx_valid = 1'b1;
      rst_n = 1'b0;
      tick;
      rx_valid = 1'b0;
      cmd_model = 0;
      err_model = 0;
      ferr_model = 1'b0;
      addr_model = 4'd0;
      check8("midrst_tx", tx_byte, 8'h00);
      check8("midrst_wdata", reg_wdata, 8'h00);
      checkOutput("midrst");
      tick;
      check8("midrst_wren", {7'd0, reg_wr_en}, 8'h00);
      rst_n = 1'b1;
      check_int("midrst_nwr", wr_log.size(), 0);
      frame_q = '{8'h0E, 8'hAB, 8'hCD, 8'hEF};
      run_frame("post_rst");

      for (int f = 0; f < 40; f++) begin
         r = $urandom;
         frame_q = {};
         frame_q.push_back({r[0], (r[4:2] == 3'd0) ? r[7:5] : 3'd0, r[11:8]});
         for (int i = 0; i < int'(r[14:12] % 3'd6); i++) frame_q.push_back(8'($urandom));
         run_frame($sformatf("rnd%0d", f));
      end

      for (int f = 0; f < 260; f++) begin
         frame_q = '{{1'b0, 3'(1 + f % 7), 4'(f)}};
         run_frame("sat_err");
      end
      check8("err_sat", err_count, 8'hFF);
      cmd_before = cmd_count;
      for (int f = 0; f < 256; f++) begin
         frame_q = '{{1'(f), 3'd0, 4'(f)}};
         run_frame("wrap_cmd");
      end
      check8("cmd_wrap", cmd_count, cmd_before);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
